debounced_input_sampler: RTL and testbench

//  I/O-clock-domain producer for the read-only register's CDC write port.

---
 rtl/kabeta_io_pkg.sv | 11 +
 rtl/input_synchronizer.sv | 25 ++
 rtl/debounced_input_sampler.sv | 118 +++++++++++
 tb/tb_debounced_input_sampler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/kabeta_io_pkg.sv
// Shared types for the I/O-clock-domain peripherals.
package kabeta_io_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } sampler_state_t;

endpackage

// File: rtl/input_synchronizer.sv
// Per-bit multi-flop synchroniser for asynchronous pin levels.
// Plain flop chain with asynchronous reset to zero; shared by I/O peripherals.
module input_synchronizer #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/debounced_input_sampler.sv
// Synchronises and debounces raw pins, then pushes each new stable vector into the
// CDC transmitter, coalescing pending updates so only the latest value is sent.
module debounced_input_sampler
  import kabeta_io_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter int unsigned           SYNC_STAGES     = 2,
  parameter int unsigned           DEBOUNCE_CYCLES = 1000,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic                  IO_Clock,
  input  logic                  IO_Reset,
  input  logic [DATA_WIDTH-1:0] Pin_In,
  input  logic                  IO_Busy,
  output logic [DATA_WIDTH-1:0] IO_WrData,
  output logic                  IO_WrEn,
  output logic [DATA_WIDTH-1:0] Stable_Out,
  output logic                  Coalesced
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] w_synced;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_stable;
  logic                  r_dirty;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_en;
  logic                  r_coalesced;
  sampler_state_t        r_state;
  sampler_state_t        w_next_state;
  logic                  w_match;
  logic                  w_update;
  logic                  w_enter_send;

  input_synchronizer #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk (IO_Clock),
    .i_rst (IO_Reset),
    .i_d   (Pin_In),
    .o_q   (w_synced)
  );

  assign w_match  = (w_synced == r_prev);
  assign w_update = w_match && (r_cnt == CNT_MAX) && (w_synced != r_stable);

  // Vector-wide debounce: any flip of any bit restarts the run length.
  always_ff @(posedge IO_Clock or posedge IO_Reset) begin
    if (IO_Reset) begin
      r_prev   <= '0;
      r_cnt    <= '0;
      r_stable <= RESET_VALUE;
    end else begin
      r_prev <= w_synced;
      if (!w_match) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_update) begin
        r_stable <= w_synced;
      end
    end
  end

  always_ff @(posedge IO_Clock or posedge IO_Reset) begin
    if (IO_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (r_dirty && !IO_Busy) w_next_state = SEND;
      SEND:      w_next_state = WAIT_BUSY;
      WAIT_BUSY: if (IO_Busy) w_next_state = WAIT_DONE;
      WAIT_DONE: if (!IO_Busy) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  assign w_enter_send = (r_state == IDLE) && (w_next_state == SEND);

  // Data and strobe are loaded on entry to SEND so they are valid together for the whole
  // SEND cycle; a Stable update on that same edge re-arms Dirty for a follow-up transfer.
  always_ff @(posedge IO_Clock or posedge IO_Reset) begin
    if (IO_Reset) begin
      r_dirty     <= 1'b0;
      r_wr_data   <= RESET_VALUE;
      r_wr_en     <= 1'b0;
      r_coalesced <= 1'b0;
    end else begin
      r_wr_en     <= w_enter_send;
      r_coalesced <= w_update && r_dirty && !w_enter_send;
      if (w_enter_send) begin
        r_wr_data <= r_stable;
      end
      if (w_update) begin
        r_dirty <= 1'b1;
      end else if (w_enter_send) begin
        r_dirty <= 1'b0;
      end
    end
  end

  assign IO_WrData  = r_wr_data;
  assign IO_WrEn    = r_wr_en;
  assign Stable_Out = r_stable;
  assign Coalesced  = r_coalesced;

endmodule

// File: tb/tb_debounced_input_sampler.sv
// Directed bench for debounced_input_sampler with a simple CDC transmitter busy model.
module tb_debounced_input_sampler;

  localparam int unsigned DW       = 8;
  localparam int          BUSY_LEN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pin;
  logic          busy;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic [DW-1:0] stable;
  logic          coalesced;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            wren_cnt = 0;
  int            coal_cnt = 0;
  int            base_w;
  int            base_c;
  logic [DW-1:0] last_data = '0;
  logic          mdl_busy   = 1'b0;
  logic          force_busy = 1'b0;
  logic          wren_prev  = 1'b0;
  int            busy_left  = 0;

  debounced_input_sampler #(
    .DATA_WIDTH      (DW),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (8'h00)
  ) dut (
    .IO_Clock   (clk),
    .IO_Reset   (rst),
    .Pin_In     (pin),
    .IO_Busy    (busy),
    .IO_WrData  (wr_data),
    .IO_WrEn    (wr_en),
    .Stable_Out (stable),
    .Coalesced  (coalesced)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the transmitter model, then observe strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wren_prev) begin
      mdl_busy  = 1'b1;
      busy_left = BUSY_LEN;
    end else if (mdl_busy) begin
      if (busy_left == 0) mdl_busy = 1'b0;
      else busy_left--;
    end
    busy      = mdl_busy | force_busy;
    wren_prev = wr_en;
    if (wr_en) begin
      wren_cnt++;
      last_data = wr_data;
      check("proto_wren_while_busy", 32'(busy), 32'(0));
    end
    if (coalesced) coal_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_force(input logic b);
    force_busy = b;
    busy       = mdl_busy | force_busy;
  endtask

  initial begin
    rst  = 1'b1;
    pin  = 8'hFF;
    busy = 1'b0;

    // Reset with all pins high
    ticks(3);
    check("rst_stable", 32'(stable), 32'h00);
    check("rst_wrdata", 32'(wr_data), 32'h00);
    check("rst_wren", 32'(wr_en), 32'(0));
    check("rst_coal", 32'(coalesced), 32'(0));
    rst = 1'b0;
    ticks(6);
    check("rst_hold_stable", 32'(stable), 32'h00);
    check("rst_no_wren", 32'(wren_cnt), 32'(0));
    tick();
    check("rst_settle_stable", 32'(stable), 32'hFF);
    check("rst_settle_wren", 32'(wr_en), 32'(0));
    tick();
    check("rst_send_wren", 32'(wr_en), 32'(1));
    check("rst_send_data", 32'(wr_data), 32'hFF);
    ticks(12);

    // Clean edge 0x00 -> 0x05
    pin = 8'h00;
    ticks(20);
    base_w = wren_cnt;
    pin = 8'h05;
    ticks(6);
    check("clean_before", 32'(stable), 32'h00);
    tick();
    check("clean_stable", 32'(stable), 32'h05);
    check("clean_no_wren_yet", 32'(wr_en), 32'(0));
    tick();
    check("clean_wren", 32'(wr_en), 32'(1));
    check("clean_data", 32'(wr_data), 32'h05);
    tick();
    check("clean_wren_width", 32'(wr_en), 32'(0));
    check("clean_data_hold", 32'(wr_data), 32'h05);
    ticks(12);
    check("clean_one_xfer", 32'(wren_cnt - base_w), 32'(1));

    // Glitch shorter than the debounce window
    pin = 8'h00;
    ticks(20);
    base_w = wren_cnt;
    base_c = coal_cnt;
    pin = 8'h01;
    ticks(3);
    pin = 8'h00;
    ticks(12);
    check("glitch_stable", 32'(stable), 32'h00);
    check("glitch_no_wren", 32'(wren_cnt - base_w), 32'(0));
    check("glitch_no_coal", 32'(coal_cnt - base_c), 32'(0));

    // Coalescing while the transmitter is held busy
    base_w = wren_cnt;
    base_c = coal_cnt;
    set_force(1'b1);
    pin = 8'h0A;
    ticks(10);
    check("coal_first_stable", 32'(stable), 32'h0A);
    check("coal_held_no_wren", 32'(wren_cnt - base_w), 32'(0));
    pin = 8'h0F;
    ticks(10);
    check("coal_second_stable", 32'(stable), 32'h0F);
    check("coal_pulse", 32'(coal_cnt - base_c), 32'(1));
    ticks(20);
    check("coal_busy_no_wren", 32'(wren_cnt - base_w), 32'(0));
    set_force(1'b0);
    ticks(12);
    check("coal_one_xfer", 32'(wren_cnt - base_w), 32'(1));
    check("coal_latest_data", 32'(last_data), 32'h0F);

    // Collision: Stable update lands on the edge that enters SEND
    set_force(1'b1);
    pin = 8'h33;
    ticks(10);
    base_w = wren_cnt;
    pin = 8'h44;
    ticks(6);
    set_force(1'b0);
    tick();
    check("coll_wren", 32'(wr_en), 32'(1));
    check("coll_old_data", 32'(wr_data), 32'h33);
    check("coll_new_stable", 32'(stable), 32'h44);
    ticks(20);
    check("coll_two_xfers", 32'(wren_cnt - base_w), 32'(2));
    check("coll_second_data", 32'(last_data), 32'h44);

    // Reset while waiting for the transfer to complete
    pin = 8'h5A;
    ticks(10);
    rst = 1'b1;
    tick();
    check("rst2_wren", 32'(wr_en), 32'(0));
    check("rst2_stable", 32'(stable), 32'h00);
    check("rst2_wrdata", 32'(wr_data), 32'h00);
    check("rst2_coal", 32'(coalesced), 32'(0));
    rst = 1'b0;
    base_w = wren_cnt;
    ticks(6);
    check("rst2_no_wren", 32'(wren_cnt - base_w), 32'(0));
    ticks(20);
    check("rst2_resend", 32'(wren_cnt - base_w), 32'(1));
    check("rst2_data", 32'(last_data), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
